// File: rtl/data_pattern_pkg.sv
// Shared encodings, word geometry and LFSR parameters for the pattern generator.
package data_pattern_pkg;

    localparam int WORD_W    = 128;
    localparam int PRBS7_W   = 7;
    localparam int PRBS7_T   = 6;
    localparam int PRBS15_W  = 15;
    localparam int PRBS15_T  = 14;
    localparam int PRBS23_W  = 23;
    localparam int PRBS23_T  = 18;
    localparam int PRBS31_W  = 31;
    localparam int PRBS31_T  = 28;

    localparam logic [WORD_W-1:0] HF_WORD = {64{2'b10}};
    localparam logic [WORD_W-1:0] LF_WORD = {8{16'hFF00}};

    typedef enum logic [2:0] {
        PAT_PRBS7   = 3'd0,
        PAT_PRBS15  = 3'd1,
        PAT_PRBS23  = 3'd2,
        PAT_PRBS31  = 3'd3,
        PAT_COUNTER = 3'd4,
        PAT_FIXED   = 3'd5,
        PAT_HIFREQ  = 3'd6,
        PAT_LOFREQ  = 3'd7
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN
    } state_e;

    // Four 32-bit lanes counting up from base, lane 0 in the low bits.
    function automatic logic [WORD_W-1:0] counter_word(input logic [31:0] base);
        logic [WORD_W-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w[32*i +: 32] = base + 32'(i);
        end
        return w;
    endfunction

endpackage

// File: rtl/prbs_parallel_step.sv
// Advances a Fibonacci LFSR by one full word of serial steps in a single cycle.
module prbs_parallel_step
    import data_pattern_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int TAP   = 6
) (
    input  logic [WIDTH-1:0]  state_i,
    output logic [WIDTH-1:0]  state_o,
    output logic [WORD_W-1:0] data_o
);

    logic [WIDTH-1:0] s;
    logic             nb;

    // Bit k of the word is the k-th serial output, so bit 0 goes on the line first.
    always_comb begin
        s      = state_i;
        nb     = 1'b0;
        data_o = '0;
        for (int k = 0; k < WORD_W; k++) begin
            nb        = s[WIDTH-1] ^ s[TAP-1];
            data_o[k] = nb;
            s         = {s[WIDTH-2:0], nb};
        end
        state_o = s;
    end

endmodule

// File: rtl/data_pattern_generator_tx.sv
// Test-pattern source feeding a FIFO: PRBS/counter/fixed/clock-like words,
// with single-word error injection and a written-word counter.
module data_pattern_generator_tx
    import data_pattern_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        pattern_sel,
    input  logic [31:0]       fixed_pattern,
    input  logic              inject_error,
    input  logic              wrfull,
    output logic [WORD_W-1:0] pattern_out_fifo_write,
    output logic              wrreq,
    output logic              running,
    output logic [31:0]       words_written
);

    state_e               state_q;
    pattern_e             sel_q, sel_d;
    logic [PRBS7_W-1:0]   p7_q, p7_d;
    logic [PRBS15_W-1:0]  p15_q, p15_d;
    logic [PRBS23_W-1:0]  p23_q, p23_d;
    logic [PRBS31_W-1:0]  p31_q, p31_d;
    logic [WORD_W-1:0]    d7, d15, d23, d31;
    logic [31:0]          base_q, base_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic                 err_q;
    logic [31:0]          cnt_q;
    logic                 seed, adv;

    assign seed  = (state_q == ST_SEED);
    assign wrreq = (state_q == ST_RUN) & ~wrfull;
    assign adv   = seed | wrreq;

    assign running                = (state_q == ST_RUN);
    assign words_written          = cnt_q;
    // A pending error flips the word currently offered, so it lands on the next accepted write.
    assign pattern_out_fifo_write = word_q ^ {{(WORD_W-1){1'b0}}, err_q};

    prbs_parallel_step #(.WIDTH(PRBS7_W), .TAP(PRBS7_T)) u_prbs7 (
        .state_i (seed ? '1 : p7_q),
        .state_o (p7_d),
        .data_o  (d7)
    );
    prbs_parallel_step #(.WIDTH(PRBS15_W), .TAP(PRBS15_T)) u_prbs15 (
        .state_i (seed ? '1 : p15_q),
        .state_o (p15_d),
        .data_o  (d15)
    );
    prbs_parallel_step #(.WIDTH(PRBS23_W), .TAP(PRBS23_T)) u_prbs23 (
        .state_i (seed ? '1 : p23_q),
        .state_o (p23_d),
        .data_o  (d23)
    );
    prbs_parallel_step #(.WIDTH(PRBS31_W), .TAP(PRBS31_T)) u_prbs31 (
        .state_i (seed ? '1 : p31_q),
        .state_o (p31_d),
        .data_o  (d31)
    );

    always_comb begin
        sel_d  = seed ? pattern_e'(pattern_sel) : sel_q;
        base_d = seed ? 32'd0 : base_q + 32'd4;
        word_d = '0;
        case (sel_d)
            PAT_PRBS7:   word_d = d7;
            PAT_PRBS15:  word_d = d15;
            PAT_PRBS23:  word_d = d23;
            PAT_PRBS31:  word_d = d31;
            PAT_COUNTER: word_d = counter_word(base_d);
            PAT_FIXED:   word_d = {4{fixed_pattern}};
            PAT_HIFREQ:  word_d = HF_WORD;
            PAT_LOFREQ:  word_d = LF_WORD;
            default:     word_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= PAT_PRBS7;
            p7_q    <= '1;
            p15_q   <= '1;
            p23_q   <= '1;
            p31_q   <= '1;
            base_q  <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= inject_error | (err_q & ~wrreq);
            if (adv) begin
                word_q <= word_d;
                base_q <= base_d;
                p7_q   <= p7_d;
                p15_q  <= p15_d;
                p23_q  <= p23_d;
                p31_q  <= p31_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_SEED;
                        cnt_q   <= '0;
                    end
                end
                ST_SEED: begin
                    state_q <= ST_RUN;
                    sel_q   <= sel_d;
                end
                ST_RUN: begin
                    if (wrreq) cnt_q <= cnt_q + 32'd1;
                    // The write of the leaving cycle still counts; a new selection reseeds.
                    if (!enable)                                state_q <= ST_IDLE;
                    else if (pattern_e'(pattern_sel) != sel_q) state_q <= ST_SEED;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_pattern_generator_tx.sv
// Scoreboard bench: stimulus queues reference words, a negedge monitor checks every accepted write.
module tb_data_pattern_generator_tx;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic [2:0]   pattern_sel = 3'd0;
    logic [31:0]  fixed_pattern = 32'd0;
    logic         inject_error = 1'b0;
    logic         wrfull = 1'b0;
    logic [127:0] pattern_out_fifo_write;
    logic         wrreq;
    logic         running;
    logic [31:0]  words_written;

    data_pattern_generator_tx dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .pattern_sel            (pattern_sel),
        .fixed_pattern          (fixed_pattern),
        .inject_error           (inject_error),
        .wrfull                 (wrfull),
        .pattern_out_fifo_write (pattern_out_fifo_write),
        .wrreq                  (wrreq),
        .running                (running),
        .words_written          (words_written)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int mon_writes = 0;
    int cnt_base = 0;
    bit tb_pend = 1'b0;
    logic [127:0] exp_q[$];
    int tap_n[4] = '{7, 15, 23, 31};
    int tap_t[4] = '{6, 14, 18, 28};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: nth word of each pattern built from the stream definition.
    function automatic void push_words(input int sel, input logic [31:0] fp, input int n);
        bit           b[$];
        logic [127:0] w;
        int           nn;
        int           tt;
        if (sel < 4) begin
            nn = tap_n[sel];
            tt = tap_t[sel];
            for (int i = 0; i < nn; i++) b.push_back(1'b1);
            for (int j = nn; j < nn + 128 * n; j++) b.push_back(b[j-nn] ^ b[j-tt]);
        end
        for (int k = 0; k < n; k++) begin
            w = '0;
            case (sel)
                4: for (int i = 0; i < 4; i++) w[32*i +: 32] = 32'(4 * k + i);
                5: w = {4{fp}};
                6: w = {64{2'b10}};
                7: w = {8{16'hFF00}};
                default: for (int i = 0; i < 128; i++) w[i] = b[nn + 128 * k + i];
            endcase
            exp_q.push_back(w);
        end
    endfunction

    function automatic logic [127:0] cnt_word(input int k);
        logic [127:0] w;
        for (int i = 0; i < 4; i++) w[32*i +: 32] = 32'(4 * k + i);
        return w;
    endfunction

    // Monitor: every accepted write is popped and compared, with error injection applied.
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                tb_pend = 1'b0;
            end else begin
                if (wrreq) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 128'(1), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        e[0] = e[0] ^ tb_pend;
                        chk("data", pattern_out_fifo_write, e);
                    end
                    chk("words_written", 128'(words_written), 128'(32'(mon_writes - cnt_base)));
                    mon_writes++;
                    tb_pend = 1'b0;
                end
                if (inject_error) tb_pend = 1'b1;
            end
        end
    end

    task automatic start_epoch(input int sel, input logic [31:0] fp, input int n);
        @(posedge clk); #1;
        pattern_sel   = 3'(sel);
        fixed_pattern = fp;
        enable        = 1'b1;
        wrfull        = 1'b0;
        inject_error  = 1'b0;
        cnt_base      = mon_writes;
        push_words(sel, fp, n);
    endtask

    // Runs until n writes are seen; the last write cycle applies end_en/end_sel.
    task automatic run_writes(input int n, input int wf_pct, input int inj_pct,
                              input logic end_en, input logic [2:0] end_sel);
        int   got = 0;
        int   cyc = 0;
        logic wf;
        while (got < n && cyc < 500) begin
            @(posedge clk); #1;
            wf           = ($urandom_range(0, 99) < 32'(wf_pct));
            wrfull       = wf;
            inject_error = ($urandom_range(0, 99) < 32'(inj_pct));
            if (running && !wf && got == n - 1) begin
                enable      = end_en;
                pattern_sel = end_sel;
            end
            @(negedge clk);
            if (wrreq) got++;
            cyc++;
        end
        chk("write_budget", 128'(got), 128'(n));
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wrreq", 128'(wrreq), 128'(0));
        chk("rst_running", 128'(running), 128'(0));
        chk("rst_data", pattern_out_fifo_write, 128'(0));
        chk("rst_words", 128'(words_written), 128'(0));
        @(posedge clk); #1 reset = 1'b0;
        cnt_base = mon_writes;

        // PRBS7 startup timing and first word
        start_epoch(0, 32'd0, 6);
        @(negedge clk);
        chk("idle_wrreq", 128'(wrreq), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("seed_wrreq", 128'(wrreq), 128'(0));
        chk("seed_running", 128'(running), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("run_wrreq", 128'(wrreq), 128'(1));
        chk("run_running", 128'(running), 128'(1));
        chk("prbs7_first7", 128'(pattern_out_fifo_write[6:0]), 128'(7'h40));
        run_writes(5, 0, 0, 1'b0, 3'd0);

        // Counter, three writes
        start_epoch(4, 32'd0, 3);
        run_writes(3, 0, 0, 1'b0, 3'd4);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cnt_words", 128'(words_written), 128'(3));
        chk("cnt_idle", 128'(running), 128'(0));

        // Backpressure hold
        start_epoch(4, 32'd0, 5);
        run_writes(2, 0, 0, 1'b1, 3'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 wrfull = 1'b1;
            @(negedge clk);
            chk("hold_wrreq", 128'(wrreq), 128'(0));
            chk("hold_data", pattern_out_fifo_write, cnt_word(2));
            chk("hold_words", 128'(words_written), 128'(2));
        end
        run_writes(3, 40, 0, 1'b0, 3'd4);

        // Error injection on PRBS31, then switch to fixed
        start_epoch(3, 32'h12345678, 6);
        push_words(5, 32'h12345678, 4);
        run_writes(2, 0, 0, 1'b1, 3'd3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wrfull       = 1'b1;
            inject_error = (i == 0 || i == 2);
            @(negedge clk);
            chk("inj_hold_wrreq", 128'(wrreq), 128'(0));
        end
        run_writes(4, 0, 0, 1'b1, 3'd5);
        @(posedge clk); #1;
        wrfull       = 1'b0;
        inject_error = 1'b0;
        @(negedge clk);
        chk("reseed_wrreq", 128'(wrreq), 128'(0));
        chk("reseed_running", 128'(running), 128'(0));
        run_writes(4, 30, 0, 1'b0, 3'd5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("reseed_words", 128'(words_written), 128'(10));

        // Randomized epochs
        for (int e = 0; e < 5; e++) begin
            int          s;
            int          n;
            logic [31:0] fp;
            s  = int'($urandom_range(0, 7));
            n  = int'($urandom_range(3, 8));
            fp = $urandom;
            start_epoch(s, fp, n);
            run_writes(n, 40, 10, 1'b0, 3'(s));
        end

        // Reset in the middle of a stream, then restart
        start_epoch(0, 32'd0, 3);
        run_writes(3, 0, 0, 1'b1, 3'd0);
        @(posedge clk); #1 wrfull = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_wrreq", 128'(wrreq), 128'(0));
        chk("midrst_running", 128'(running), 128'(0));
        chk("midrst_data", pattern_out_fifo_write, 128'(0));
        chk("midrst_words", 128'(words_written), 128'(0));
        @(posedge clk); #1;
        reset    = 1'b0;
        cnt_base = mon_writes;
        push_words(0, 32'd0, 2);
        run_writes(2, 20, 0, 1'b0, 3'd0);

        @(posedge clk); #1;
        @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_pattern_generator_tx.md
DATA_PATTERN_GENERATOR_TX -- requirements
Module: data_pattern_generator_tx

Interface
REQ-001 SHALL have port clk, input, 1, single clock for all logic (FIFO write clock domain).
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port enable, input, 1, level: generator runs while high.
REQ-004 SHALL have port pattern_sel, input, 3, pattern: 0 PRBS7, 1 PRBS15, 2 PRBS23, 3 PRBS31, 4 counter, 5 fixed, 6 high-freq, 7 low-freq.
REQ-005 SHALL have port fixed_pattern, input, 32, word replicated for fixed mode.
REQ-006 SHALL have port inject_error, input, 1, single-cycle request to corrupt one word.
REQ-007 SHALL have port wrfull, input, 1, downstream FIFO full flag.
REQ-008 SHALL have port pattern_out_fifo_write, output, 128, FIFO write data; bit 0 is the first serial bit.
REQ-009 SHALL have port wrreq, output, 1, FIFO write strobe.
REQ-010 SHALL have port running, output, 1, high in RUN state.
REQ-011 SHALL have port words_written, output, 32, count of accepted writes, wraps at 2^32.

Function
REQ-012 SHALL implement FSM states IDLE, SEED, RUN.
REQ-013 SHALL transition IDLE->SEED when enable=1, SEED->RUN after exactly one cycle, RUN->IDLE when enable=0, and RUN->SEED when pattern_sel differs from the value latched at SEED.
REQ-014 SHALL, in SEED, latch pattern_sel, load all LFSRs with all-ones, zero the counter base, and load pattern_out_fifo_write with the first word of the selected pattern.
REQ-015 SHALL drive wrreq combinationally as (state==RUN) & ~wrfull; a word counts as written only in a cycle with wrreq=1.
REQ-016 SHALL hold pattern_out_fifo_write stable while wrreq=0 and advance it to the next word on the clock edge after each wrreq=1 cycle.
REQ-017 SHALL generate PRBS serially-equivalent: new = s[n-1]^s[t-1], s <= {s[n-2:0],new}, output bit = new; taps (n,t) = (7,6), (15,14), (23,18), (31,28); 128 steps per word.
REQ-018 SHALL, in counter mode, output four 32-bit lanes lane[i] = base+i, base starting at 0 and incrementing by 4 per written word, modulo 2^32.
REQ-019 SHALL output {4{fixed_pattern}} in fixed mode, sampled at SEED and at each advance.
REQ-020 SHALL output 128'hAAAA...AAAA in high-freq mode and {8{16'hFF00}} in low-freq mode.
REQ-021 SHALL latch an inject_error pulse (any state) into a pending flag and invert bit 0 of the next written word only; the flag clears on that write; the generator state is not altered.
REQ-022 SHALL treat multiple inject_error pulses before one write as a single error.
REQ-023 SHALL increment words_written on every wrreq=1 cycle and clear it only on reset or IDLE->SEED.
REQ-024 SHALL, on enable deassert with wrfull=0 in the same cycle, still issue that cycle's wrreq (RUN state is current).

Reset
REQ-025 SHALL on reset force state IDLE, wrreq=0, running=0, pattern_out_fifo_write=0, words_written=0, pending error=0, LFSRs all-ones.
REQ-026 SHALL, on reset asserted mid-stream, drop wrreq in the same cycle (asynchronous) and resume only via SEED.

Structure
REQ-027 SHALL place the pattern_sel encoding enum, LFSR widths/taps and word width (128) in a shared package data_pattern_pkg.
REQ-028 SHALL implement the 128-step parallel LFSR as sub-module prbs_parallel_step (parameters width, tap; combinational state-in to state-out plus 128-bit data).

Verification
REQ-029 SHALL test reset then enable=1, sel=0, wrfull=0 -> wrreq high from 2nd cycle after enable; first word bits[6:0]=7'h40; every stream bit i>=7 satisfies b[i]=b[i-7]^b[i-6].
REQ-030 SHALL test counter mode, 3 writes -> words {3,2,1,0}, {7,6,5,4}, {11,10,9,8}; words_written=3.
REQ-031 SHALL test wrfull held high 5 cycles in RUN -> wrreq=0, data unchanged, words_written frozen; on release the held word is written once.
REQ-032 SHALL test inject_error pulsed twice while wrfull=1 -> exactly the next written word has bit 0 inverted; following word matches golden PRBS31.
REQ-033 SHALL test pattern_sel 3->5 during RUN with fixed_pattern=32'h12345678 -> one SEED cycle with wrreq=0, then words = {4{32'h12345678}}.
REQ-034 SHALL test reset asserted mid-stream -> wrreq drops immediately, all outputs at reset values, restart reproduces the first word of the stream.
